mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst as elsewhere in the codebase.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request strobe, sampled at a rising edge only while busy=0.
REQ-005 op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-006 A  in  32  dividend / multiplicand / MTHI-MTLO data; sampled only together with an accepted start.
REQ-007 B  in  32  divisor / multiplier; sampled only together with an accepted start.
REQ-008 busy  out  1  combinational; high while state is not IDLE, and used by the CPU to stall.
REQ-009 done  out  1  registered one-cycle pulse; high in the first cycle in which the new HI/LO values are visible.
REQ-010 div_zero  out  1  registered one-cycle pulse, coincident with done, for DIV or DIVU with B=0.
REQ-011 hi, lo  out  32 each  architectural HI and LO registers, driven directly from flops.

Function
REQ-012 States SHALL be IDLE, MUL, DIV and FIX.
REQ-013 Cycle numbering: start is high in cycle 0 and accepted at edge E0; edge En ends cycle n.
REQ-014 MULT/MULTU: operands and sign flag latch at E0 -> state MUL for cycle 1 -> 64-bit product written at E1 (hi=[63:32], lo=[31:0]) -> done in cycle 2 -> state IDLE.
REQ-015 MULT SHALL sign-extend both operands to 64 bits; MULTU SHALL zero-extend both; the product is exact modulo 2^64.
REQ-016 DIV/DIVU with B not 0: operand magnitudes (DIV) or raw values (DIVU) latch at E0, together with the quotient and remainder sign flags.
REQ-017 The divide SHALL then run states DIV for cycles 1..32, performing one restoring shift-subtract step per cycle with a 5-bit step counter that counts 0..31.
REQ-018 The divide SHALL then run state FIX in cycle 33, where signs are applied; hi=remainder and lo=quotient are written at E33, and done is high in cycle 34.
REQ-019 Signed divide: quotient truncates toward zero; remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no trap).
REQ-020 DIV/DIVU with B=0: no iteration; hi and lo are unchanged; done and div_zero pulse in cycle 1; busy never rises.
REQ-021 MTHI/MTLO: A is written to hi (MTHI) or lo (MTLO) at E0; done pulses in cycle 1; the other register is unchanged; busy never rises.
REQ-022 A reserved op with start=1 SHALL be ignored: no state change and no done.
REQ-023 start while busy=1 SHALL be ignored with no queueing; the CPU must hold it until busy=0.
REQ-024 start in the same cycle that done is high SHALL be accepted normally, giving back-to-back operation.
REQ-025 hi and lo SHALL NOT change at any time other than the write edges given in REQ-014, REQ-018 and REQ-021.
REQ-026 Busy cycles per operation: MULT/MULTU 1; DIV/DIVU 33; all others 0.

Reset
REQ-027 While rst=1: state=IDLE, hi=0, lo=0, done=0, div_zero=0, step counter=0, all operand/partial registers=0, and busy=0 immediately (combinational).
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start is accepted at the first edge after rst deasserts.

Structure
REQ-029 The shared package mdu_pkg SHALL hold the op encodings, the state enumeration and DIV_STEPS=32.
REQ-030 Multiplication SHALL instantiate the team's existing combinational multiplier MUL (sign_flag, A, B -> HI, LO) on the latched operands; no other sub-module.
REQ-031 The divider datapath SHALL stay inside mdu_ctrl as a 64-bit remainder/quotient shift register and a 33-bit subtractor.

Verification
REQ-032 MULT A=0xFFFFFFFF, B=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done in cycle 2; MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 DIV A=0xFFFFFFF9 (-7), B=2 -> busy cycles 1..33, done in cycle 34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU 100/7 -> lo=14, hi=2.
REQ-034 DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, div_zero=0.
REQ-035 DIVU A=100, B=0 with hi/lo preloaded to 0x11111111/0x22222222 -> done=1 and div_zero=1 in cycle 1, hi/lo unchanged, busy=0 throughout.
REQ-036 MTHI 0x12345678 then, in the done cycle, MTLO 0x9ABCDEF0 -> hi=0x12345678 and lo=0x9ABCDEF0 one edge apart; a MULT start issued at DIV cycle 5 is ignored.
REQ-037 rst asserted in DIV cycle 10 -> busy=0, hi=lo=0 immediately, no done pulse; a MULTU 3*5 started after release -> lo=15, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op_* : 3-bit operation encodings presented on mdu_ctrl.op
//   - state_e : controller states
//   - DIV_STEPS : number of restoring shift-subtract iterations
//   - cond_neg : two's-complement negate when a flag is set
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int DIV_STEPS = 32;
    localparam logic [4:0] LAST_STEP = 5'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_ctrl_mul.sv
// MUL: combinational 32x32 -> 64 multiplier.
//   sign_flag : 1 = both operands signed (sign-extended), 0 = unsigned
//   A, B      : operands
//   HI, LO    : upper and lower halves of the product (exact modulo 2^64)
module MUL (
    input  logic        sign_flag,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    always_comb begin
        ext_a = sign_flag ? {{32{A[31]}}, A} : {32'd0, A};
        ext_b = sign_flag ? {{32{B[31]}}, B} : {32'd0, B};
        // Low 64 bits of the extended product equal the exact product mod 2^64.
        prod  = ext_a * ext_b;
        HI    = prod[63:32];
        LO    = prod[31:0];
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller with architectural HI/LO.
//   clk, rst      : clock, asynchronous active-high reset
//   start, op     : request strobe and operation (accepted only while idle)
//   A, B          : operands, captured with an accepted start
//   busy          : combinational, high while an operation is in flight
//   done          : one-cycle pulse when new HI/LO values become visible
//   div_zero      : one-cycle pulse with done for a divide by zero
//   hi, lo        : architectural HI and LO registers
// Multiply takes one busy cycle through the MUL sub-module; divide runs a
// 32-step restoring divider followed by a sign-fix cycle.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_e      state_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q, div_zero_q;
    logic [31:0] a_q, b_q;
    logic        sign_q;
    logic [63:0] rq_q, rq_d;
    logic [4:0]  cnt_q;
    logic        q_neg_q, r_neg_q;

    logic        sdiv;
    logic [31:0] dvd_mag, dvs_mag;
    logic [32:0] diff;
    logic [31:0] mul_hi, mul_lo;
    logic [31:0] q_fix, r_fix;

    MUL u_mul (
        .sign_flag (sign_q),
        .A         (a_q),
        .B         (b_q),
        .HI        (mul_hi),
        .LO        (mul_lo)
    );

    always_comb begin
        sdiv    = (op == OP_DIV);
        dvd_mag = cond_neg(sdiv & A[31], A);
        dvs_mag = cond_neg(sdiv & B[31], B);
        // Trial subtract of the divisor from the shifted partial remainder;
        // diff[32] set means borrow, i.e. keep the shifted remainder.
        diff    = rq_q[63:31] - {1'b0, b_q};
        rq_d    = diff[32] ? {rq_q[62:0], 1'b0}
                           : {diff[31:0], rq_q[30:0], 1'b1};
        q_fix   = cond_neg(q_neg_q, rq_q[31:0]);
        r_fix   = cond_neg(r_neg_q, rq_q[63:32]);
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            sign_q     <= 1'b0;
            rq_q       <= 64'd0;
            cnt_q      <= 5'd0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_q     <= A;
                                b_q     <= B;
                                sign_q  <= (op == OP_MULT);
                                state_q <= MUL;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (B == 32'd0) begin
                                    done_q     <= 1'b1;
                                    div_zero_q <= 1'b1;
                                end else begin
                                    rq_q    <= {32'd0, dvd_mag};
                                    b_q     <= dvs_mag;
                                    // Quotient negative on differing signs; remainder follows dividend.
                                    q_neg_q <= sdiv & (A[31] ^ B[31]);
                                    r_neg_q <= sdiv & A[31];
                                    cnt_q   <= 5'd0;
                                    state_q <= DIV;
                                end
                            end
                            OP_MTHI: begin
                                hi_q   <= A;
                                done_q <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo_q   <= A;
                                done_q <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                MUL: begin
                    hi_q    <= mul_hi;
                    lo_q    <= mul_lo;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                DIV: begin
                    rq_q  <= rq_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= r_fix;
                    lo_q    <= q_fix;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl with a cycle-level reference model.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    mdu_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: remaining busy cycles plus pending result, arithmetic
    // done directly on 64-bit integers.
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
    logic        m_done = 1'b0, m_dz = 1'b0;

    always @(posedge clk or posedge rst) begin
        longint sa, sb, ua, ub, p;
        if (rst) begin
            m_left = 0; m_hi = 0; m_lo = 0; m_done = 0; m_dz = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            ua = longint'({32'd0, A});
            ub = longint'({32'd0, B});
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = m_phi; m_lo = m_plo; m_done = 1;
                end
            end else if (start) begin
                case (op)
                    3'd0, 3'd1: begin
                        p = (op == 3'd0) ? sa * sb : ua * ub;
                        m_phi = p[63:32]; m_plo = p[31:0]; m_left = 1;
                    end
                    3'd2, 3'd3: begin
                        if (B == 0) begin
                            m_done = 1; m_dz = 1;
                        end else begin
                            if (op == 3'd2) begin
                                m_plo = 32'(sa / sb); m_phi = 32'(sa % sb);
                            end else begin
                                m_plo = 32'(ua / ub); m_phi = 32'(ua % ub);
                            end
                            m_left = 33;
                        end
                    end
                    3'd4: begin m_hi = A; m_done = 1; end
                    3'd5: begin m_lo = A; m_done = 1; end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("div_zero", {31'd0, div_zero}, {31'd0, m_dz});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
        end
    end

    // Issues one operation with start high in cycle 0 only; returns the cycle
    // number in which done is observed (0 on timeout) and div_zero there.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cyc, output logic dz);
        @(posedge clk); #2;
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #2;
        start = 1'b0;
        cyc = 0;
        dz  = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done) begin
                cyc = n;
                dz  = div_zero;
                break;
            end
        end
        if (cyc == 0) begin
            n_chk++;
            $display("FAIL done_timeout actual=none required=done within 60 cycles op=%0d", o);
        end
    endtask

    int   cyc;
    logic dz;

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        run_op(3'd0, 32'hFFFFFFFF, 32'd2, cyc, dz);
        chk("mult_cyc", cyc, 2);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFE);

        run_op(3'd1, 32'hFFFFFFFF, 32'd2, cyc, dz);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        run_op(3'd2, 32'hFFFFFFF9, 32'd2, cyc, dz);
        chk("div_cyc", cyc, 34);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        run_op(3'd3, 32'd100, 32'd7, cyc, dz);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, cyc, dz);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);
        chk("ovf_dz", {31'd0, dz}, 32'd0);

        run_op(3'd4, 32'h11111111, 32'd0, cyc, dz);
        chk("mthi_cyc", cyc, 1);
        run_op(3'd5, 32'h22222222, 32'd0, cyc, dz);
        run_op(3'd3, 32'd100, 32'd0, cyc, dz);
        chk("dz_cyc", cyc, 1);
        chk("dz_flag", {31'd0, dz}, 32'd1);
        chk("dz_hi", hi, 32'h11111111);
        chk("dz_lo", lo, 32'h22222222);

        // MTHI followed by MTLO issued in the MTHI done cycle.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd4; A = 32'h12345678;
        @(posedge clk); #2;
        op = 3'd5; A = 32'h9ABCDEF0;
        @(negedge clk);
        chk("b2b_done1", {31'd0, done}, 32'd1);
        chk("b2b_hi", hi, 32'h12345678);
        chk("b2b_lo_old", lo, 32'h22222222);
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_lo", lo, 32'h9ABCDEF0);

        // Reserved opcodes are ignored.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd6; A = 32'hDEADBEEF; B = 32'd1;
        @(posedge clk); #2 op = 3'd7;
        @(posedge clk); #2 start = 1'b0;
        @(negedge clk);
        chk("rsv_done", {31'd0, done}, 32'd0);
        chk("rsv_hi", hi, 32'h12345678);

        // MULT request in DIV cycle 5 must be dropped.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd3; A = 32'd1000; B = 32'd10;
        @(posedge clk); #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd3;
        @(posedge clk); #2 start = 1'b0;
        cyc = 0;
        for (int n = 6; n <= 60; n++) begin
            @(negedge clk);
            if (done) begin cyc = n; break; end
        end
        chk("ign_cyc", cyc, 34);
        chk("ign_lo", lo, 32'd100);
        chk("ign_hi", hi, 32'd0);
        repeat (3) @(negedge clk);
        chk("ign_nomul_lo", lo, 32'd100);

        // Reset in DIV cycle 10 aborts the divide.
        @(posedge clk); #2;
        start = 1'b1; op = 3'd2; A = 32'hFFFFFFF9; B = 32'd2;
        @(posedge clk); #2 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        run_op(3'd1, 32'd3, 32'd5, cyc, dz);
        chk("post_cyc", cyc, 2);
        chk("post_lo", lo, 32'd15);
        chk("post_hi", hi, 32'd0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
